// File: rtl/exc_entry_ctrl.sv
// CP0 exception/interrupt entry and eret controller at the M stage.
// Holds SR, Cause and PRId; drives the EPC write side and the pipeline redirect.
module exc_entry_ctrl #(
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] PRID_VAL   = 32'h2017_1226
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  hw_int,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic        m_bd,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic        eret_m,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  input  logic [31:0] epc_q,
  output logic        epc_pcwe,
  output logic [31:0] epc_pc,
  output logic        epc_we,
  output logic [31:0] epc_din,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic        exl,
  output logic [31:0] cp0_rdata
);

  typedef enum logic {StNormal = 1'b0, StHandler = 1'b1} state_e;

  localparam logic [4:0] AddrSr    = 5'd12;
  localparam logic [4:0] AddrCause = 5'd13;
  localparam logic [4:0] AddrEpc   = 5'd14;
  localparam logic [4:0] AddrPrid  = 5'd15;

  state_e      state_q, state_d;
  logic [5:0]  im_q, im_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [4:0]  code_q, code_d;
  logic [5:0]  ip_q;
  logic [31:0] last_pc_q;
  logic        last_bd_q;

  logic [31:0] victim_pc;
  logic        victim_bd;
  logic        int_take, exc_take, take, eret_do, mtc0_do;
  logic [31:0] sr_val, cause_val;

  always_ff @(posedge clk) begin
    // IP tracks the interrupt lines unconditionally, reset included.
    ip_q <= hw_int;
    if (reset) begin
      state_q   <= StNormal;
      im_q      <= 6'd0;
      ie_q      <= 1'b0;
      bd_q      <= 1'b0;
      code_q    <= 5'd0;
      last_pc_q <= 32'd0;
      last_bd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      im_q    <= im_d;
      ie_q    <= ie_d;
      bd_q    <= bd_d;
      code_q  <= code_d;
      if (m_valid) begin
        last_pc_q <= m_pc;
        last_bd_q <= m_bd;
      end
    end
  end

  always_comb begin
    victim_pc = m_valid ? m_pc : last_pc_q;
    victim_bd = m_valid ? m_bd : last_bd_q;
    int_take  = ie_q & (|(hw_int & im_q));
    exc_take  = exc_valid & m_valid;
    take      = (state_q == StNormal) & (int_take | exc_take);
    eret_do   = eret_m & m_valid & ~take;
    mtc0_do   = cp0_we & m_valid & ~take & ~eret_m;
    sr_val    = {16'd0, im_q, 8'd0, (state_q == StHandler), ie_q};
    cause_val = {bd_q, 15'd0, ip_q, 3'd0, code_q, 2'd0};
  end

  always_comb begin
    state_d = state_q;
    im_d    = im_q;
    ie_d    = ie_q;
    bd_d    = bd_q;
    code_d  = code_q;
    if (take) begin
      state_d = StHandler;
      bd_d    = victim_bd;
      code_d  = int_take ? 5'd0 : exc_code;
    end else if (eret_do) begin
      state_d = StNormal;
    end else if (mtc0_do && cp0_addr == AddrSr) begin
      im_d    = cp0_wdata[15:10];
      state_d = cp0_wdata[1] ? StHandler : StNormal;
      ie_d    = cp0_wdata[0];
    end
  end

  always_comb begin
    epc_pcwe    = 1'b0;
    epc_pc      = 32'd0;
    epc_we      = 1'b0;
    epc_din     = 32'd0;
    flush       = 1'b0;
    redirect_pc = 32'd0;
    exl         = 1'b0;
    cp0_rdata   = 32'd0;
    if (!reset) begin
      epc_pcwe = take;
      epc_pc   = victim_bd ? victim_pc - 32'd4 : victim_pc;
      epc_we   = mtc0_do & (cp0_addr == AddrEpc);
      epc_din  = cp0_wdata;
      flush    = take | eret_do;
      if (take) begin
        redirect_pc = HANDLER_PC;
      end else if (eret_do) begin
        redirect_pc = epc_q;
      end
      exl = (state_q == StHandler);
      case (cp0_addr)
        AddrSr:    cp0_rdata = sr_val;
        AddrCause: cp0_rdata = cause_val;
        AddrEpc:   cp0_rdata = epc_q;
        AddrPrid:  cp0_rdata = PRID_VAL;
        default:   cp0_rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_entry_ctrl.sv
// Scoreboard bench for exc_entry_ctrl: a reference model pushes expected outputs per
// cycle, a negedge monitor pops and compares them against the DUT.
module tb_exc_entry_ctrl;

  localparam logic [31:0] HANDLER = 32'h0000_4180;
  localparam logic [31:0] PRID    = 32'h2017_1226;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  hw_int;
  logic        m_valid, m_bd, exc_valid, eret_m, cp0_we;
  logic [31:0] m_pc, cp0_wdata, epc_q;
  logic [4:0]  exc_code, cp0_addr;
  logic        epc_pcwe, epc_we, flush, exl;
  logic [31:0] epc_pc, epc_din, redirect_pc, cp0_rdata;

  exc_entry_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .hw_int      (hw_int),
    .m_valid     (m_valid),
    .m_pc        (m_pc),
    .m_bd        (m_bd),
    .exc_valid   (exc_valid),
    .exc_code    (exc_code),
    .eret_m      (eret_m),
    .cp0_we      (cp0_we),
    .cp0_addr    (cp0_addr),
    .cp0_wdata   (cp0_wdata),
    .epc_q       (epc_q),
    .epc_pcwe    (epc_pcwe),
    .epc_pc      (epc_pc),
    .epc_we      (epc_we),
    .epc_din     (epc_din),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .exl         (exl),
    .cp0_rdata   (cp0_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pcwe;
    logic [31:0] epc_pc;
    logic        epc_we;
    logic [31:0] epc_din;
    logic        flush;
    logic [31:0] redir;
    logic        exl;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Architectural state of the reference model.
  logic [5:0]  s_im, s_ip;
  logic        s_ie, s_exl, s_bd;
  logic [4:0]  s_code;
  logic [31:0] s_last_pc;
  logic        s_last_bd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("epc_pcwe", {31'd0, epc_pcwe}, {31'd0, e.pcwe});
      chk("flush", {31'd0, flush}, {31'd0, e.flush});
      chk("redirect_pc", redirect_pc, e.redir);
      chk("epc_we", {31'd0, epc_we}, {31'd0, e.epc_we});
      chk("exl", {31'd0, exl}, {31'd0, e.exl});
      chk("cp0_rdata", cp0_rdata, e.rdata);
      if (e.pcwe || reset) chk("epc_pc", epc_pc, e.epc_pc);
      if (e.epc_we) chk("epc_din", epc_din, e.epc_din);
    end
  end

  task automatic idle();
    reset = 1'b0; hw_int = 6'd0; m_valid = 1'b1; m_pc = 32'h0000_3000; m_bd = 1'b0;
    exc_valid = 1'b0; exc_code = 5'd0; eret_m = 1'b0; cp0_we = 1'b0;
    cp0_addr = 5'd0; cp0_wdata = 32'd0; epc_q = 32'd0;
  endtask

  // Predict this cycle's outputs from the model, then advance the model across the edge.
  task automatic tick();
    exp_t        e;
    logic [31:0] vpc;
    logic        vbd, irq, enter, ret, wr;
    e = '{pcwe: 1'b0, epc_pc: 32'd0, epc_we: 1'b0, epc_din: 32'd0, flush: 1'b0,
          redir: 32'd0, exl: 1'b0, rdata: 32'd0};
    vpc   = m_valid ? m_pc : s_last_pc;
    vbd   = m_valid ? m_bd : s_last_bd;
    irq   = s_ie && ((hw_int & s_im) != 6'd0);
    enter = !s_exl && (irq || (exc_valid && m_valid));
    ret   = eret_m && m_valid && !enter;
    wr    = cp0_we && m_valid && !enter && !eret_m;
    if (!reset) begin
      e.pcwe    = enter;
      e.epc_pc  = vbd ? vpc - 32'd4 : vpc;
      e.epc_we  = wr && cp0_addr == 5'd14;
      e.epc_din = cp0_wdata;
      e.flush   = enter || ret;
      e.redir   = enter ? HANDLER : (ret ? epc_q : 32'd0);
      e.exl     = s_exl;
      case (cp0_addr)
        5'd12:   e.rdata = {16'd0, s_im, 8'd0, s_exl, s_ie};
        5'd13:   e.rdata = {s_bd, 15'd0, s_ip, 3'd0, s_code, 2'd0};
        5'd14:   e.rdata = epc_q;
        5'd15:   e.rdata = PRID;
        default: e.rdata = 32'd0;
      endcase
    end
    exp_q.push_back(e);
    @(posedge clk);
    s_ip = hw_int;
    if (reset) begin
      s_im = 0; s_ie = 0; s_exl = 0; s_bd = 0; s_code = 0; s_last_pc = 0; s_last_bd = 0;
    end else begin
      if (enter) begin
        s_exl  = 1'b1;
        s_bd   = vbd;
        s_code = irq ? 5'd0 : exc_code;
      end else if (ret) begin
        s_exl = 1'b0;
      end else if (wr && cp0_addr == 5'd12) begin
        s_im  = cp0_wdata[15:10];
        s_exl = cp0_wdata[1];
        s_ie  = cp0_wdata[0];
      end
      if (m_valid) begin
        s_last_pc = m_pc;
        s_last_bd = m_bd;
      end
    end
    #1;
  endtask

  initial begin
    s_im = 0; s_ip = 0; s_ie = 0; s_exl = 0; s_bd = 0; s_code = 0; s_last_pc = 0; s_last_bd = 0;
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    tick();
    reset = 1'b1; tick();
    // Enable IE with IM=1.
    idle(); cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0401; tick();
    // Interrupt entry at 0x3008.
    idle(); hw_int = 6'h01; m_pc = 32'h0000_3008; cp0_addr = 5'd12; tick();
    idle(); hw_int = 6'h01; cp0_addr = 5'd13; tick();
    idle(); eret_m = 1'b1; epc_q = 32'h0000_3008; cp0_addr = 5'd13; tick();
    // Exception in a delay slot.
    idle(); exc_valid = 1'b1; exc_code = 5'd12; m_pc = 32'h0000_3010; m_bd = 1'b1; tick();
    idle(); cp0_addr = 5'd13; tick();
    idle(); eret_m = 1'b1; epc_q = 32'h0000_300C; tick();
    // Interrupt and exception together.
    idle(); hw_int = 6'h01; exc_valid = 1'b1; exc_code = 5'd4; m_pc = 32'h0000_3018; tick();
    idle(); cp0_addr = 5'd13; tick();
    idle(); eret_m = 1'b1; tick();
    // Bubble in M takes the last valid PC.
    idle(); m_pc = 32'h0000_3020; tick();
    idle(); m_valid = 1'b0; m_pc = 32'h0000_BAD0; hw_int = 6'h01; tick();
    // No nesting in the handler; pending interrupt retaken right after eret.
    idle(); hw_int = 6'h01; exc_valid = 1'b1; exc_code = 5'd10; cp0_addr = 5'd12; tick();
    idle(); hw_int = 6'h01; eret_m = 1'b1; epc_q = 32'h0000_3024; tick();
    idle(); hw_int = 6'h01; m_pc = 32'h0000_3024; tick();
    idle(); eret_m = 1'b1; tick();
    // mtc0 EPC, eret in NORMAL, then SR write colliding with an interrupt take.
    idle(); cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'hDEAD_BEE0; tick();
    idle(); eret_m = 1'b1; epc_q = 32'h0000_5000; tick();
    idle(); hw_int = 6'h01; cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'd0; tick();
    idle(); cp0_addr = 5'd12; tick();
    // Reset mid-handler.
    idle(); reset = 1'b1; hw_int = 6'h01; tick();
    idle(); cp0_addr = 5'd15; tick();

    for (int i = 0; i < 3000; i++) begin
      idle();
      reset     = ($urandom_range(0, 99) == 0);
      hw_int    = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      m_valid   = ($urandom_range(0, 3) != 0);
      m_pc      = {$urandom_range(0, 32'h0FFF_FFFF), 2'b00} ^ 32'($urandom_range(0, 1) << 31);
      m_bd      = $urandom_range(0, 1) == 1;
      exc_valid = ($urandom_range(0, 7) == 0);
      exc_code  = 5'($urandom);
      eret_m    = ($urandom_range(0, 7) == 0);
      cp0_we    = ($urandom_range(0, 4) == 0);
      cp0_addr  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(12, 15));
      cp0_wdata = $urandom;
      epc_q     = $urandom;
      tick();
    end

    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
